// File: rtl/mesh_skew_feeder.sv
// mesh_skew_feeder
//   Input stage for the 4x1 mesh. It accepts one ROWS-wide vector of A/B/D
//   operands per cycle on a valid/ready handshake. It then applies a
//   triangular skew: lane i reaches the mesh i cycles after lane 0.
//   Each lane also carries its own valid bit and a propagate bit. The
//   propagate bit flips at every tile boundary.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_valid   input vector valid
//   in_ready   feeder accepts the vector this cycle
//   in_a/b/d   ROWS*IN_W operands; lane i = bits [i*IN_W +: IN_W]
//   in_last    final vector of a stream
//   out_a/b/d  skewed operands, same packing (lane i -> *_buf_i_0)
//   out_valid  per-lane valid (lane i -> io_in_valid_i_0)
//   out_prop   per-lane propagate (lane i -> in_i_prop)
//   busy       FSM not idle
module mesh_skew_feeder #(
  parameter int ROWS     = 4,
  parameter int IN_W     = 8,
  parameter int TILE_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*IN_W-1:0] in_a,
  input  logic [ROWS*IN_W-1:0] in_b,
  input  logic [ROWS*IN_W-1:0] in_d,
  input  logic                 in_last,
  output logic [ROWS*IN_W-1:0] out_a,
  output logic [ROWS*IN_W-1:0] out_b,
  output logic [ROWS*IN_W-1:0] out_d,
  output logic [ROWS-1:0]      out_valid,
  output logic [ROWS-1:0]      out_prop,
  output logic                 busy
);

  localparam int CNT_W = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
  localparam int DC_W  = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_q, par_d;
  logic [DC_W-1:0]   dcnt_q, dcnt_d;
  logic              accept;
  logic [ROWS-1:0]   lane_busy;
  logic              pipe_empty;

  assign in_ready   = (state_q != DRAIN) && !reset;
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != IDLE);
  assign pipe_empty = ~|lane_busy;

  // Lane i is an (i+1)-deep shift register of {valid, prop, a, b, d}.
  // A cycle without an accept pushes an all-zero bubble into the lane.
  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    logic [i:0]      v_q;
    logic [i:0]      p_q;
    logic [IN_W-1:0] a_q [0:i];
    logic [IN_W-1:0] b_q [0:i];
    logic [IN_W-1:0] d_q [0:i];

    // NOTE: the stage data arrays are reset together with the valids.
    // Reset must flush in-flight vectors, so the lanes have to emit
    // all-zero data on the following cycle.
    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= '0;
        p_q <= '0;
        for (int k = 0; k <= i; k++) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
          d_q[k] <= '0;
        end
      end else begin
        // NOTE: non-blocking assignments make every stage sample the value
        // its predecessor held before this edge. That behaviour is what
        // makes the loop act as a shift register.
        v_q[0] <= accept;
        p_q[0] <= accept & par_q;
        a_q[0] <= accept ? in_a[i*IN_W +: IN_W] : '0;
        b_q[0] <= accept ? in_b[i*IN_W +: IN_W] : '0;
        d_q[0] <= accept ? in_d[i*IN_W +: IN_W] : '0;
        for (int k = 1; k <= i; k++) begin
          v_q[k] <= v_q[k-1];
          p_q[k] <= p_q[k-1];
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
          d_q[k] <= d_q[k-1];
        end
      end
    end

    assign lane_busy[i]            = |v_q;
    assign out_valid[i]            = v_q[i];
    assign out_prop[i]             = p_q[i];
    assign out_a[i*IN_W +: IN_W]   = a_q[i];
    assign out_b[i*IN_W +: IN_W]   = b_q[i];
    assign out_d[i*IN_W +: IN_W]   = d_q[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first. This ensures that no path
    // through the case leaves a variable unassigned, so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    dcnt_d  = dcnt_q;

    // A tile ends after TILE_LEN accepts, or earlier at the end of a stream.
    if (accept) begin
      if (cnt_q == CNT_W'(TILE_LEN - 1) || in_last) begin
        cnt_d = '0;
        par_d = ~par_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_last) begin
            state_d = DRAIN;
            dcnt_d  = DC_W'(ROWS - 1);
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (accept && in_last) begin
          state_d = DRAIN;
          dcnt_d  = DC_W'(ROWS - 1);
        end else if (!accept && pipe_empty) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        // The last accepted vector leaves lane ROWS-1 during the cycle in
        // which the count reads 0.
        if (dcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mesh_skew_feeder.sv
// Testbench for mesh_skew_feeder (ROWS=4, IN_W=8, TILE_LEN=4).
// Inputs are driven just after the falling edge. Outputs are sampled 1ns
// later, which is well away from the rising edge.
module tb_mesh_skew_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b, in_d;
  logic        in_last;
  logic [31:0] out_a, out_b, out_d;
  logic [3:0]  out_valid, out_prop;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  mesh_skew_feeder #(.ROWS(4), .IN_W(8), .TILE_LEN(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_last(in_last),
    .out_a(out_a), .out_b(out_b), .out_d(out_d),
    .out_valid(out_valid), .out_prop(out_prop), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        il;
    logic [31:0] a, b, d;
    logic [3:0]  ev, ep;
    logic [31:0] ea, eb, ed;
    logic        er, ebusy;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic il, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] d, input logic rst);
    @(negedge clk);
    reset    = rst;
    in_valid = iv;
    in_last  = il;
    in_a     = a;
    in_b     = b;
    in_d     = d;
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    // Tests 1 and 3: single vector skew, then accept / bubble / accept.
    // Inputs with iv=0 carry junk data, which must not reach the outputs.
    tbl[0]  = '{1'b1, 1'b0, 32'h04030201, 32'h14131211, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h1, 4'h0, 32'h00000001, 32'h00000011, 32'h0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0, 4'h2, 4'h0, 32'h00000200, 32'h00001200, 32'h0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h4, 4'h0, 32'h00030000, 32'h00130000, 32'h0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h8, 4'h0, 32'h04000000, 32'h14000000, 32'h0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h44332211, 32'hB4B3B2B1, 32'hD4D3D2D1, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h1, 4'h0, 32'h00000011, 32'h000000B1, 32'h000000D1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 32'h88776655, 32'hB8B7B6B5, 32'hD8D7D6D5, 4'h2, 4'h0, 32'h00002200, 32'h0000B200, 32'h0000D200, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h5, 4'h0, 32'h00330055, 32'h00B300B5, 32'h00D300D5, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'hA, 4'h0, 32'h44006600, 32'hB400B600, 32'hD400D600, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h4, 4'h0, 32'h00770000, 32'h00B70000, 32'h00D70000, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h8, 4'h0, 32'h88000000, 32'hB8000000, 32'hD8000000, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; in_d = '0;
    do_reset();
    check("reset_valid", {28'h0, out_valid}, 32'h0);
    check("reset_busy",  {31'h0, busy}, 32'h0);
    check("reset_ready", {31'h0, in_ready}, 32'h1);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].iv, tbl[i].il, tbl[i].a, tbl[i].b, tbl[i].d, 1'b0);
      check($sformatf("tbl%0d_valid", i), {28'h0, out_valid}, {28'h0, tbl[i].ev});
      check($sformatf("tbl%0d_prop", i),  {28'h0, out_prop},  {28'h0, tbl[i].ep});
      check($sformatf("tbl%0d_a", i), out_a, tbl[i].ea);
      check($sformatf("tbl%0d_b", i), out_b, tbl[i].eb);
      check($sformatf("tbl%0d_d", i), out_d, tbl[i].ed);
      check($sformatf("tbl%0d_ready", i), {31'h0, in_ready}, {31'h0, tbl[i].er});
      check($sformatf("tbl%0d_busy", i),  {31'h0, busy},     {31'h0, tbl[i].ebusy});
    end

    // Test 2: 8 back-to-back accepts; prop flips after the 4th (tile length).
    do_reset();
    for (int c = 0; c < 12; c++) begin
      logic [7:0] lv;
      lv = 8'(c + 1);
      step(c < 8, 1'b0, {lv, lv, lv, lv}, '0, '0, 1'b0);
      check($sformatf("t2_c%0d_v0", c), {31'h0, out_valid[0]}, {31'h0, (c >= 1 && c <= 8)});
      check($sformatf("t2_c%0d_p0", c), {31'h0, out_prop[0]},  {31'h0, (c >= 5 && c <= 8)});
      check($sformatf("t2_c%0d_a0", c), {24'h0, out_a[7:0]},   (c >= 1 && c <= 8) ? c : 0);
      check($sformatf("t2_c%0d_v3", c), {31'h0, out_valid[3]}, {31'h0, (c >= 4 && c <= 11)});
      check($sformatf("t2_c%0d_p3", c), {31'h0, out_prop[3]},  {31'h0, (c >= 8 && c <= 11)});
      check($sformatf("t2_c%0d_a3", c), {24'h0, out_a[31:24]}, (c >= 4 && c <= 11) ? c - 3 : 0);
    end

    // Test 4: in_last on the 3rd accept; 4-cycle drain, next tile prop=1.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      step(1'b1, c == 2, 32'h0A0B0C0D, '0, '0, 1'b0);
      check($sformatf("t4_c%0d_ready", c), {31'h0, in_ready}, {31'h0, !(c >= 3 && c <= 6)});
      check($sformatf("t4_c%0d_busy", c),  {31'h0, busy}, {31'h0, ((c >= 1 && c <= 6) || c == 8)});
      check($sformatf("t4_c%0d_v0", c),    {31'h0, out_valid[0]}, {31'h0, ((c >= 1 && c <= 3) || c == 8)});
      check($sformatf("t4_c%0d_v3", c),    {31'h0, out_valid[3]}, {31'h0, (c >= 4 && c <= 6)});
    end
    check("t4_next_prop", {31'h0, out_prop[0]}, 32'h1);

    // Test 5: reset mid-stream (after par has flipped); nothing stale emerges.
    do_reset();
    for (int c = 0; c < 13; c++) begin
      step(c <= 6, 1'b0, 32'h55555555, 32'h66666666, 32'h77777777, c == 5);
      if (c == 5) check("t5_ready_in_reset", {31'h0, in_ready}, 32'h0);
      if (c == 6) begin
        check("t5_post_valid", {28'h0, out_valid}, 32'h0);
        check("t5_post_prop",  {28'h0, out_prop}, 32'h0);
        check("t5_post_a",     out_a, 32'h0);
        check("t5_post_d",     out_d, 32'h0);
        check("t5_post_busy",  {31'h0, busy}, 32'h0);
        check("t5_post_ready", {31'h0, in_ready}, 32'h1);
      end
      if (c >= 7) begin
        check($sformatf("t5_c%0d_valid", c), {28'h0, out_valid}, (c <= 10) ? (32'h1 << (c - 7)) : 32'h0);
        check($sformatf("t5_c%0d_prop", c),  {28'h0, out_prop}, 32'h0);
      end
    end

    // Reset during DRAIN: the drain state and counter are abandoned.
    do_reset();
    step(1'b1, 1'b1, 32'h01010101, '0, '0, 1'b0);
    step(1'b1, 1'b0, 32'h02020202, '0, '0, 1'b0);
    check("drain_ready", {31'h0, in_ready}, 32'h0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0);
    check("drain_rst_ready", {31'h0, in_ready}, 32'h1);
    check("drain_rst_busy",  {31'h0, busy}, 32'h0);
    check("drain_rst_valid", {28'h0, out_valid}, 32'h0);

    // Test 6: in_last held high; accepts every ROWS+1 cycles, par toggles.
    do_reset();
    for (int c = 0; c < 17; c++) begin
      step(1'b1, 1'b1, 32'h11223344, '0, '0, 1'b0);
      check($sformatf("t6_c%0d_ready", c), {31'h0, in_ready}, {31'h0, (c % 5 == 0)});
      if (c % 5 == 1) begin
        check($sformatf("t6_c%0d_v0", c), {31'h0, out_valid[0]}, 32'h1);
        check($sformatf("t6_c%0d_p0", c), {31'h0, out_prop[0]}, (c / 5) % 2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
